// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the instruction/data SRAM port arbiter.
// Holds the read-owner encoding and the default starvation limit.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_IF   = 2'b01,
    OWN_MEM  = 2'b10
  } owner_e;

  localparam int MAX_WAIT_DEF = 4;

endpackage

// File: rtl/mem_port_arbiter_hold_buf.sv
// Fetch-side read-data hold buffer: parks a returning word while if_hold.
// Ports: rvalid_in/rdata_in (raw return), hold, rvalid_out/rdata_out, block_gnt.
module mem_port_arbiter_hold_buf (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rvalid_in,
  input  logic [31:0] rdata_in,
  input  logic        hold,
  output logic        rvalid_out,
  output logic [31:0] rdata_out,
  output logic        block_gnt
);

  logic        held_q;
  logic        held_d;
  logic [31:0] buf_q;
  logic [31:0] buf_d;

  always_comb begin
    held_d     = held_q;
    buf_d      = buf_q;
    rvalid_out = 1'b0;
    rdata_out  = '0;
    if (held_q) begin
      rvalid_out = 1'b1;
      rdata_out  = buf_q;
      if (!hold) held_d = 1'b0;
    end else begin
      rvalid_out = rvalid_in;
      rdata_out  = rvalid_in ? rdata_in : '0;
      if (rvalid_in && hold) begin
        held_d = 1'b1;
        buf_d  = rdata_in;
      end
    end
    // Also block on the capture cycle: a grant there would return
    // data into an already occupied buffer.
    block_gnt = held_q | (rvalid_in & hold);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      held_q <= 1'b0;
      buf_q  <= '0;
    end else begin
      held_q <= held_d;
      buf_q  <= buf_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/mem) arbiter onto one single-port SRAM.
// Ports: if_* fetch, mem_* data, sram_* memory, stallreq_*; ARB_FAIR_EN adds anti-starvation.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int AW       = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          if_hold,
  input  logic          mem_req,
  input  logic [3:0]    mem_wen,
  input  logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_wdata,
  output logic          mem_gnt,
  output logic          mem_rvalid,
  output logic [31:0]   mem_rdata,
  output logic          sram_en,
  output logic [3:0]    sram_wen,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata,
  output logic          stallreq_if,
  output logic          stallreq_mem
);

  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("MAX_WAIT must be at least 1");
  end

  owner_e owner_q;
  owner_e owner_d;
  logic   if_block;
  logic   if_ok;
  logic   mem_ok;
  logic   if_rv_raw;

`ifdef ARB_FAIR_EN
  localparam int SW = $clog2(MAX_WAIT + 1);
  logic [SW-1:0] starve_q;
  logic [SW-1:0] starve_d;
  logic          if_prio;
`endif

  always_comb begin
    if_ok   = resetn & if_req & ~if_block;
    mem_ok  = resetn & mem_req;
    if_gnt  = 1'b0;
    mem_gnt = 1'b0;
`ifdef ARB_FAIR_EN
    if_prio = (starve_q == SW'(MAX_WAIT));
    if (if_ok && if_prio)  if_gnt  = 1'b1;
    else if (mem_ok)       mem_gnt = 1'b1;
    else if (if_ok)        if_gnt  = 1'b1;
`else
    if (mem_ok)            mem_gnt = 1'b1;
    else if (if_ok)        if_gnt  = 1'b1;
`endif
  end

`ifdef ARB_FAIR_EN
  // Count only denials caused by mem winning, not hold-buffer blocks.
  always_comb begin
    starve_d = starve_q;
    if (if_gnt)
      starve_d = '0;
    else if (if_ok && mem_gnt && !if_prio)
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) starve_q <= '0;
    else         starve_q <= starve_d;
  end
`endif

  always_comb begin
    sram_en    = if_gnt | mem_gnt;
    sram_wen   = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    unique case (1'b1)
      if_gnt: begin
        sram_addr = if_addr;
      end
      mem_gnt: begin
        sram_wen   = mem_wen;
        sram_addr  = mem_addr;
        sram_wdata = mem_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (if_gnt)                       owner_d = OWN_IF;
    else if (mem_gnt && mem_wen == '0) owner_d = OWN_MEM;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) owner_q <= OWN_NONE;
    else         owner_q <= owner_d;
  end

  assign if_rv_raw    = (owner_q == OWN_IF);
  assign mem_rvalid   = (owner_q == OWN_MEM);
  assign mem_rdata    = mem_rvalid ? sram_rdata : '0;
  assign stallreq_if  = resetn & if_req & ~if_gnt;
  assign stallreq_mem = resetn & mem_req & ~mem_gnt;

  mem_port_arbiter_hold_buf inst_hold_buf (
    .clk        (clk),
    .resetn     (resetn),
    .rvalid_in  (if_rv_raw),
    .rdata_in   (sram_rdata),
    .hold       (if_hold),
    .rvalid_out (if_rvalid),
    .rdata_out  (if_rdata),
    .block_gnt  (if_block)
  );

endmodule
